// File: rtl/sr_latch_ctrl.sv
// Sequencer driving the active-low S/R inputs of one NAND SR latch with timed pulses and gaps.
// Optional latch readback check is compiled in with SR_LATCH_CTRL_VERIFY_EN.
module sr_latch_ctrl #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic done,
    output logic err,
    input  logic err_clr,
    output logic last_op,
    output logic s_n,
    output logic r_n,
    input  logic lq,
    input  logic lqn
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    localparam logic [7:0] PulseLoad = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GapLoad   = 8'(GAP_CYCLES - 1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       op_q;
    logic       gap_exit;

    assign busy     = (state_q != StIdle);
    assign gap_exit = (state_q == StGap) && (cnt_q == 8'd0);

    // s_n and r_n only ever fall from IDLE and both rise together, so they can never both be low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            op_q    <= 1'b0;
            s_n     <= 1'b1;
            r_n     <= 1'b1;
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            done    <= 1'b0;
            last_op <= 1'b0;
        end else begin
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        op_q    <= 1'b0;
                        r_n     <= 1'b0;
                        clr_ack <= 1'b1;
                        cnt_q   <= PulseLoad;
                        state_q <= StPulse;
                    end else if (set_req) begin
                        op_q    <= 1'b1;
                        s_n     <= 1'b0;
                        set_ack <= 1'b1;
                        cnt_q   <= PulseLoad;
                        state_q <= StPulse;
                    end
                end
                StPulse: begin
                    if (cnt_q == 8'd0) begin
                        s_n     <= 1'b1;
                        r_n     <= 1'b1;
                        cnt_q   <= GapLoad;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= StIdle;
                        done    <= 1'b1;
                        last_op <= op_q;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    s_n     <= 1'b1;
                    r_n     <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef SR_LATCH_CTRL_VERIFY_EN
    logic lq_s1, lq_s2, lqn_s1, lqn_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lq_s1  <= 1'b0;
            lq_s2  <= 1'b0;
            lqn_s1 <= 1'b0;
            lqn_s2 <= 1'b0;
        end else begin
            lq_s1  <= lq;
            lq_s2  <= lq_s1;
            lqn_s1 <= lqn;
            lqn_s2 <= lqn_s1;
        end
    end

    // A mismatch on the exit edge beats a simultaneous err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (gap_exit && ({lq_s2, lqn_s2} != (op_q ? 2'b10 : 2'b01))) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_readback;

    assign unused_readback = ^{lq, lqn, err_clr, gap_exit};
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: transaction-timing model plus directed scenarios.
module tb_sr_latch_ctrl;

    localparam int P = 2;
    localparam int G = 3;
`ifdef SR_LATCH_CTRL_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic set_req = 1'b0, clr_req = 1'b0, err_clr = 1'b0;
    logic set_ack, clr_ack, busy, done, err, last_op, s_n, r_n, lq, lqn;
    logic stuck_q0 = 1'b0;

    logic set_req2 = 1'b0;
    logic set_ack2, clr_ack2, busy2, done2, err2, last_op2, s_n2, r_n2;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    sr_latch_ctrl #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) u_dut (
        .clk(clk), .reset(reset), .set_req(set_req), .clr_req(clr_req),
        .set_ack(set_ack), .clr_ack(clr_ack), .busy(busy), .done(done),
        .err(err), .err_clr(err_clr), .last_op(last_op), .s_n(s_n), .r_n(r_n),
        .lq(lq), .lqn(lqn)
    );

    sr_latch_ctrl #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) u_dut2 (
        .clk(clk), .reset(reset), .set_req(set_req2), .clr_req(1'b0),
        .set_ack(set_ack2), .clr_ack(clr_ack2), .busy(busy2), .done(done2),
        .err(err2), .err_clr(1'b0), .last_op(last_op2), .s_n(s_n2), .r_n(r_n2),
        .lq(1'b0), .lqn(1'b1)
    );

    // Behavioural NAND latch; stuck_q0 forces the Q readback low.
    logic q_m = 1'b0, qn_m = 1'b1;
    always @(s_n or r_n) begin
        if (!s_n && !r_n) begin
            q_m = 1'b1; qn_m = 1'b1;
        end else if (!s_n) begin
            q_m = 1'b1; qn_m = 1'b0;
        end else if (!r_n) begin
            q_m = 1'b0; qn_m = 1'b1;
        end
    end
    assign lq  = stuck_q0 ? 1'b0 : q_m;
    assign lqn = qn_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation at edge t0 fully determines outputs at edge t0+rel.
    bit m_active = 1'b0;
    bit m_op = 1'b0;
    bit m_last = 1'b0;
    bit m_err = 1'b0;
    int m_t0 = 0;

    always begin : compare
        logic sreq, creq, eclr, rst_s, idle_before, done_edge;
        logic [1:0] pair;
        int rel;
        @(posedge clk);
        sreq = set_req; creq = clr_req; eclr = err_clr; rst_s = reset;
        pair = {lq, lqn};
        k++;
        if (rst_s) begin
            m_active = 1'b0; m_last = 1'b0; m_err = 1'b0;
        end else begin
            idle_before = !m_active || (k > m_t0 + P + G);
            done_edge   = m_active && (k == m_t0 + P + G);
            if (done_edge) m_last = m_op;
            if (VerifyEn && done_edge && (pair != (m_op ? 2'b10 : 2'b01))) m_err = 1'b1;
            else if (VerifyEn && eclr) m_err = 1'b0;
            if (idle_before && (creq || sreq)) begin
                m_active = 1'b1; m_t0 = k; m_op = !creq;
            end
        end
        #1;
        rel = k - m_t0;
        chk("m_set_ack", set_ack, m_active && rel == 0 && m_op);
        chk("m_clr_ack", clr_ack, m_active && rel == 0 && !m_op);
        chk("m_s_n", s_n, !(m_active && m_op && rel < P));
        chk("m_r_n", r_n, !(m_active && !m_op && rel < P));
        chk("m_busy", busy, m_active && rel < P + G);
        chk("m_done", done, m_active && rel == P + G);
        chk("m_last_op", last_op, m_last);
        chk("m_err", err, m_err);
        chk("never_both_low", s_n | r_n, 1);
    end

    // which: 0 set_ack, 1 clr_ack, 2 done; returns the edge index it was seen at.
    task automatic wait_for(input int which, input string name, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && set_ack) || (which == 1 && clr_ack) || (which == 2 && done)) begin
                at = k;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got no event expected one within 40 cycles", name);
        end
    endtask

    initial begin : stim
        int a0, a1, d0;
        int acks[$];
        int dones[$];
        repeat (3) @(negedge clk);
        chk("rst_s_n", s_n, 1);
        chk("rst_r_n", r_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_last_op", last_op, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single set
        set_req = 1'b1;
        wait_for(0, "set_ack", a0);
        chk("set_s_n_low", s_n, 0);
        @(negedge clk); set_req = 1'b0;
        wait_for(2, "set_done", d0);
        chk("set_done_latency", d0 - a0, 5);
        chk("set_last_op", last_op, 1);
        chk("set_busy_at_done", busy, 0);

        // Simultaneous requests: clear first, set follows
        @(negedge clk); set_req = 1'b1; clr_req = 1'b1;
        wait_for(1, "both_clr_ack", a0);
        chk("both_r_n_low", r_n, 0);
        chk("both_s_n_high", s_n, 1);
        @(negedge clk); clr_req = 1'b0;
        wait_for(0, "both_set_ack", a1);
        chk("both_set_after", a1 - a0, 6);
        @(negedge clk); set_req = 1'b0;
        wait_for(2, "both_done", d0);
        chk("both_last_op", last_op, 1);

        // Clear raised during a set pulse is held off until IDLE
        @(negedge clk); set_req = 1'b1;
        wait_for(0, "mid_set_ack", a0);
        @(negedge clk); set_req = 1'b0; clr_req = 1'b1;
        wait_for(1, "mid_clr_ack", a1);
        chk("mid_clr_delay", a1 - a0, 6);
        @(negedge clk); clr_req = 1'b0;
        wait_for(2, "mid_done", d0);
        chk("mid_last_op", last_op, 0);

        // Readback: stuck Q then recovery
        @(negedge clk); stuck_q0 = 1'b1; set_req = 1'b1;
        wait_for(0, "stuck_ack", a0);
        @(negedge clk); set_req = 1'b0;
        wait_for(2, "stuck_done", d0);
        chk("stuck_err", err, VerifyEn ? 1 : 0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_cleared", err, 0);
        stuck_q0 = 1'b0; clr_req = 1'b1;
        wait_for(1, "good_clr_ack", a0);
        @(negedge clk); clr_req = 1'b0;
        wait_for(2, "good_clr_done", d0);
        chk("good_clr_err", err, 0);
        @(negedge clk); set_req = 1'b1;
        wait_for(0, "good_set_ack", a0);
        @(negedge clk); set_req = 1'b0;
        wait_for(2, "good_set_done", d0);
        chk("good_set_err", err, 0);

        // Async reset during a pulse
        @(negedge clk); set_req = 1'b1;
        wait_for(0, "rst_mid_ack", a0);
        @(negedge clk); set_req = 1'b0; reset = 1'b1;
        #1;
        chk("rst_mid_s_n", s_n, 1);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_no_done", done, 0);
            chk("rst_mid_no_ack", set_ack, 0);
        end

        // Continuous set on the P=1, G=1 instance
        @(negedge clk); set_req2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (set_ack2) acks.push_back(i);
            if (done2) dones.push_back(i);
        end
        @(negedge clk); set_req2 = 1'b0;
        chk("cont_ack_count", acks.size(), 4);
        chk("cont_done_count", dones.size(), 4);
        if (acks.size() == 4 && dones.size() == 4) begin
            chk("cont_first_ack", acks[0], 0);
            for (int i = 0; i < 4; i++) begin
                chk("cont_done_pos", dones[i], acks[i] + 2);
                if (i < 3) chk("cont_ack_period", acks[i + 1] - acks[i], 3);
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected one before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous sequencer that owns the active-low S/R inputs of one NAND SR latch. It arbitrates set and clear requests from two clients and drives glitch-free, registered pulses of programmable width, with a guard gap after each pulse. The illegal S=R=0 condition is impossible by construction. Optionally, the block reads back the latch outputs through a synchronizer and flags a mismatch. It sits between the UART control logic and each asynchronous flag latch in the design.

## Interface
- Clock is `clk`; reset is `reset`, asynchronous, active-high.
- PULSE_CYCLES, default 2: cycles S or R is held low; legal range 1..255.
- GAP_CYCLES, default 3: cycles both S and R are held high after a pulse; legal range 1..255, and ≥3 when verify is compiled in.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  async active-high reset.
- set_req  in  1  level request to set the latch (Q=1).
- clr_req  in  1  level request to clear the latch (Q=0).
- set_ack  out  1  one-cycle pulse: set request accepted.
- clr_ack  out  1  one-cycle pulse: clear request accepted.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- err  out  1  sticky readback-mismatch flag.
- err_clr  in  1  clears err (synchronous).
- last_op  out  1  last completed operation: 1=set, 0=clear.
- s_n  out  1  latch S input, active-low, registered.
- r_n  out  1  latch R input, active-low, registered.
- lq  in  1  latch Q, asynchronous readback.
- lqn  in  1  latch Qn, asynchronous readback.

## Operation
- FSM states: IDLE, PULSE, GAP. An 8-bit down-counter `cnt` times both PULSE and GAP. A 1-bit `op` register holds the accepted operation.
- IDLE:
  - s_n=r_n=1.
  - If clr_req=1: op←0, r_n←0, clr_ack←1, cnt←PULSE_CYCLES-1, go to PULSE.
  - Else if set_req=1: op←1, s_n←0, set_ack←1, same load, go to PULSE.
  - When both requests are asserted in the same cycle, clear wins. The set request stays pending and is served next if it is still asserted.
- PULSE:
  - Hold the selected input low.
  - When cnt=0: s_n←1, r_n←1, cnt←GAP_CYCLES-1, go to GAP.
  - Otherwise decrement cnt.
- GAP:
  - Both inputs high.
  - When cnt=0: go to IDLE, done←1, last_op←op, and update err (see Configuration).
  - Otherwise decrement cnt.
- s_n and r_n come straight from flops and never change in the same cycle in opposite directions. s_n=0 and r_n=0 in the same cycle is forbidden.
- Requests are not sampled outside IDLE. A requester must hold its request until it sees its ack. Deasserting a request before ack cancels it with no side effect.
- err_clr takes effect every cycle. If err_clr coincides with the err-setting edge, the set wins.
- Reset values: s_n=1, r_n=1, set_ack=0, clr_ack=0, busy=0, done=0, err=0, last_op=0, state=IDLE, cnt=0, synchronizer flops=0.
- Reset asserted mid-pulse releases s_n/r_n to 1 immediately, without waiting for a clock. The latch keeps whatever state it reached.

## Timing
- Request high before edge E0 in IDLE: at E0 the ack pulse and the low S/R are both visible. That gives 1 cycle acceptance latency.
- The S/R input is low for exactly PULSE_CYCLES cycles, E0..E0+P.
- It is then high for GAP_CYCLES cycles.
- At E0+P+G: state=IDLE, done=1 for one cycle, last_op and err are valid.
- busy is high from E0 to E0+P+G.
- The earliest next acceptance edge is E0+P+G+1, so the back-to-back period is P+G+1 cycles.

## Configuration
- Macro SR_LATCH_CTRL_VERIFY_EN.
- Defined:
  - lq and lqn pass through a 2-flop synchronizer.
  - At the GAP exit edge, expected = (op ? {1,0} : {0,1}) on {lq,lqn}. Any mismatch sets err, including the 1/1 illegal-state pattern.
- Undefined:
  - No synchronizer; lq and lqn are ignored.
  - err is held at 0 and err_clr has no effect.
  - Timing is unchanged.

## Test plan
- Reset, then set_req=1 with P=2, G=3 → set_ack at E0, s_n low 2 cycles, done at E0+5, last_op=1, r_n stays 1 throughout.
- set_req and clr_req high together → clr_ack first with r_n low. set_ack follows at E0+6 with s_n low; s_n/r_n never both 0.
- clr_req pulsed during PULSE of a set operation → ignored until IDLE, then served with clr_ack at E0+6.
- VERIFY_EN with a latch model whose lq is stuck at 0, then a set → err=1 at done. err_clr=1 for one cycle → err=0. A correct latch model leaves err=0.
- Reset asserted at cycle 1 of a pulse → s_n=1 asynchronously, busy=0, no done, no ack on the following cycles.
- Continuous set_req with P=1, G=1 → set_ack every 3 cycles, done one cycle before each ack.
